// File: rtl/board_mem_arbiter_if.sv
// Board RAM arbiter bus: display/engine/loader request channels plus the
// registered single-port RAM command and read-data return.
// master: requesters and RAM side. slave: the arbiter.
interface board_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic              disp_rdata;

  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic              eng_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic              ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic              ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_rdata;

  modport master (
    output disp_req, disp_addr,
    output eng_req, eng_we, eng_addr, eng_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  disp_rvalid, disp_rdata,
    input  eng_gnt, eng_rvalid, eng_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_req, disp_addr,
    input  eng_req, eng_we, eng_addr, eng_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output disp_rvalid, disp_rdata,
    output eng_gnt, eng_rvalid, eng_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: display has absolute priority, engine and loader share
// the remaining cycles round-robin. RAM command is registered; reads are
// tagged through a 2-stage pipeline so data returns to the right requester.
// Optional starvation monitor: define BOARD_ARB_STARVE_EN.
module board_mem_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned STARVE_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  board_mem_arbiter_if.slave bus,
  input  logic               starve_clr,
  output logic               starve
);
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_ENG, OWN_LDR} owner_e;
  typedef enum logic {RR_ENG, RR_LDR} rr_e;

  owner_e            owner;
  logic              eng_gnt, ldr_gnt;
  rr_e               rr_q, rr_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wdata_q, mem_wdata_d;
  owner_e            tag0_q, tag0_d, tag1_q, tag1_d;
  logic              disp_rvalid, eng_rvalid, ldr_rvalid;

  // Grant decode: display first, then the lone requester or the rr choice
  always_comb begin
    owner   = OWN_NONE;
    eng_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (bus.disp_req) begin
      owner = OWN_DISP;
    end else if (bus.eng_req && (!bus.ldr_req || rr_q == RR_ENG)) begin
      owner   = OWN_ENG;
      eng_gnt = 1'b1;
    end else if (bus.ldr_req) begin
      owner   = OWN_LDR;
      ldr_gnt = 1'b1;
    end
  end

  // Next command, rr pointer and read-tag pipeline from the cycle owner
  always_comb begin
    rr_d        = rr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag0_d      = OWN_NONE;
    tag1_d      = tag0_q;
    unique case (owner)
      OWN_DISP: begin
        mem_en_d   = 1'b1;
        mem_addr_d = bus.disp_addr;
        tag0_d     = OWN_DISP;
      end
      OWN_ENG: begin
        rr_d        = RR_LDR;
        mem_en_d    = 1'b1;
        mem_we_d    = bus.eng_we;
        mem_addr_d  = bus.eng_addr;
        mem_wdata_d = bus.eng_wdata;
        tag0_d      = bus.eng_we ? OWN_NONE : OWN_ENG;
      end
      OWN_LDR: begin
        rr_d        = RR_ENG;
        mem_en_d    = 1'b1;
        mem_we_d    = bus.ldr_we;
        mem_addr_d  = bus.ldr_addr;
        mem_wdata_d = bus.ldr_wdata;
        tag0_d      = bus.ldr_we ? OWN_NONE : OWN_LDR;
      end
      default: ;
    endcase
  end

  // State registers; reset drops any in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q        <= RR_ENG;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 1'b0;
      tag0_q      <= OWN_NONE;
      tag1_q      <= OWN_NONE;
    end else begin
      rr_q        <= rr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
    end
  end

  assign disp_rvalid = (tag1_q == OWN_DISP);
  assign eng_rvalid  = (tag1_q == OWN_ENG);
  assign ldr_rvalid  = (tag1_q == OWN_LDR);

  assign bus.eng_gnt     = eng_gnt;
  assign bus.ldr_gnt     = ldr_gnt;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.disp_rvalid = disp_rvalid;
  assign bus.eng_rvalid  = eng_rvalid;
  assign bus.ldr_rvalid  = ldr_rvalid;
  // Read data is gated by the owner's valid so idle outputs stay at 0
  assign bus.disp_rdata  = bus.mem_rdata & disp_rvalid;
  assign bus.eng_rdata   = bus.mem_rdata & eng_rvalid;
  assign bus.ldr_rdata   = bus.mem_rdata & ldr_rvalid;

`ifdef BOARD_ARB_STARVE_EN
  localparam logic [7:0] SAT = 8'(STARVE_MAX);
  logic [7:0] eng_cnt_q, eng_cnt_d, ldr_cnt_q, ldr_cnt_d;
  logic       starve_q, starve_d;

  // Denied-cycle counters; a new saturation beats a same-cycle clear
  always_comb begin
    eng_cnt_d = '0;
    ldr_cnt_d = '0;
    if (bus.eng_req && !eng_gnt)
      eng_cnt_d = (eng_cnt_q == SAT) ? eng_cnt_q : eng_cnt_q + 8'd1;
    if (bus.ldr_req && !ldr_gnt)
      ldr_cnt_d = (ldr_cnt_q == SAT) ? ldr_cnt_q : ldr_cnt_q + 8'd1;
    starve_d = starve_q;
    if (starve_clr)
      starve_d = 1'b0;
    if (eng_cnt_d == SAT || ldr_cnt_d == SAT)
      starve_d = 1'b1;
  end

  // Starvation monitor registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt_q <= '0;
      ldr_cnt_q <= '0;
      starve_q  <= 1'b0;
    end else begin
      eng_cnt_q <= eng_cnt_d;
      ldr_cnt_q <= ldr_cnt_d;
      starve_q  <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  logic [8:0] unused_starve;
  assign unused_starve = {starve_clr, 8'(STARVE_MAX)};
  assign starve        = 1'b0;
`endif
endmodule
